instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Sequences the combinational InstructionMemory: owns the PC, drives its Address port,
//  captures the returned Instruction into a small FIFO, and hands {PC, instruction} to
//  decode over a valid/ready handshake. Handles start, branch/jump redirect with flush,
//  decode back-pressure and a halt opcode. Sits between InstructionMemory and decode.
// PARAMETERS
//  RESET_PC    32'h00000000  PC loaded on reset; word aligned
//  QDEPTH      2             fetch FIFO entries; power of 2, >= 2
//  HALT_INSTR  32'hFFFFFFFF  instruction word that stops fetching
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high
//  Start       in   1   pulse; IDLE -> RUN
//  Redirect    in   1   pulse; flush FIFO and load RedirectPC
//  RedirectPC  in   32  new PC; bits [1:0] forced to 0
//  Address     out  32  to InstructionMemory.Address; always equals PC
//  Instruction in   32  from InstructionMemory.Instruction; valid same cycle
//  OutValid    out  1   FIFO head valid
//  OutReady    in   1   decode accepts head this cycle
//  OutInstr    out  32  head instruction
//  OutPC       out  32  address of head instruction
//  Halted      out  1   state == HALTED
//  FetchCount  out  16  instructions pushed since reset; wraps at 2^16
// BEHAVIOUR
//  Reset (async): state IDLE, PC=RESET_PC, FIFO empty, OutValid=0, OutInstr=0, OutPC=0,
//   Halted=0, FetchCount=0. Mid-operation reset discards all FIFO contents immediately.
//  States: IDLE -(Start)-> RUN; RUN -(HALT_INSTR pushed)-> HALTED; HALTED exits only by reset.
//  pop  = OutValid & OutReady. fetch = (state==RUN) & !Redirect & (!full | pop).
//  On fetch: push {PC, Instruction}; PC <= PC+4 (mod 2^32, 0xFFFFFFFC -> 0); FetchCount++.
//  If the pushed word == HALT_INSTR: it is still pushed, PC holds, next state HALTED.
//  Latency: word fetched at edge n is visible on OutValid/OutInstr after edge n
//   (1 cycle); with OutReady held high, RUN sustains 1 instruction/cycle.
//  Full & !pop: no fetch, PC and FetchCount hold. Full & pop: push and pop same edge.
//  Empty & fetch & pop impossible (OutValid=0); no bypass path from Instruction to OutInstr.
//  Handshake: while OutValid & !OutReady, OutInstr/OutPC/OutValid hold stable.
//  Redirect (any state except HALTED): FIFO flushed (OutValid=0 next cycle), PC <=
//   {RedirectPC[31:2],2'b00}, no push that cycle; a simultaneous pop is discarded by the
//   flush. Redirect beats halt detection and Start. In IDLE: loads PC, stays IDLE.
//   In HALTED: ignored.
//  Start outside IDLE ignored. Start & Redirect together in IDLE: PC loaded, -> RUN.
//  HALTED: no fetches; FIFO drains normally; Halted=1 even while FIFO still holds words.
// TESTING (bench memory: word i at 4*i = 32'h1000_0000+i, word 6 = HALT_INSTR)
//  1. Reset, Start, OutReady=1 -> OutPC 0,4,8,.. on consecutive cycles, OutInstr
//     10000000,10000001,..; first OutValid 1 cycle after the first RUN edge.
//  2. OutReady=0 for 5 cycles in RUN -> FIFO fills to 2, Address holds 0x8,
//     FetchCount=2, OutInstr stays 10000000; release -> order 0,4,8 unbroken.
//  3. Redirect to 32'h0000000E while FIFO holds 2 -> next OutValid=0, PC=0xC, then
//     OutPC=0xC with 10000003; flushed words never appear.
//  4. Run to address 0x18 -> HALT_INSTR delivered at OutPC=0x18, Halted=1,
//     Address frozen at 0x18, FetchCount=7; later Start/Redirect ignored.
//  5. Assert reset mid-stream with OutValid=1 -> OutValid=0, Address=RESET_PC, state
//     IDLE before the next clock edge.
//  6. RESET_PC=32'hFFFFFFF8, Start -> Address FFFFFFF8, FFFFFFFC, 00000000 (wrap).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the combinational instruction memory and
// buffers {PC, instruction} pairs in a small FIFO for decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned QDEPTH     = 2,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstr,
  output logic [31:0] OutPC,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   instr_mem_q [QDEPTH];
  logic [31:0]   pc_mem_q    [QDEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   fetch_cnt_q;

  logic full;
  logic pop;
  logic fetch;
  logic redirect_act;
  logic start_act;

  // Fetch/pop qualification; redirect suppresses the push and flushes the queue.
  always_comb begin
    full         = (count_q == CW'(QDEPTH));
    pop          = OutValid & OutReady;
    redirect_act = Redirect & (state_q != HALTED);
    start_act    = Start & (state_q == IDLE);
    fetch        = (state_q == RUN) & ~Redirect & (~full | pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fetch_cnt_q <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (redirect_act) begin
      // Flush discards any simultaneous pop along with the queued words.
      pc_q     <= RedirectPC & ~32'h0000_0003;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      if (start_act) begin
        state_q <= RUN;
      end
    end else begin
      if (start_act) begin
        state_q <= RUN;
      end
      if (fetch) begin
        instr_mem_q[wr_ptr_q] <= Instruction;
        pc_mem_q[wr_ptr_q]    <= pc_q;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
        fetch_cnt_q           <= fetch_cnt_q + 16'd1;
        if (Instruction == HALT_INSTR) begin
          state_q <= HALTED;
        end else begin
          pc_q <= pc_q + 32'd4;
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (fetch && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!fetch && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign Address    = pc_q;
  assign OutValid   = (count_q != '0);
  assign OutInstr   = instr_mem_q[rd_ptr_q];
  assign OutPC      = pc_mem_q[rd_ptr_q];
  assign Halted     = (state_q == HALTED);
  assign FetchCount = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random stimulus compared every
// cycle against a queue-based reference model of the fetch pipeline.
module tb_instr_fetch_unit;

  localparam int          QD   = 2;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, redirect, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] address, instruction, out_instr, out_pc;
  logic        out_valid, halted;
  logic [15:0] fetch_count;

  logic        start_w, out_ready_w;
  logic [31:0] address_w, instruction_w, out_instr_w, out_pc_w;
  logic        out_valid_w, halted_w;
  logic [15:0] fetch_count_w;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    return (idx == 32'd6) ? HALT : 32'h1000_0000 + idx;
  endfunction

  assign instruction   = mem_word(address);
  assign instruction_w = mem_word(address_w);

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .Start(start), .Redirect(redirect),
    .RedirectPC(redirect_pc), .Address(address), .Instruction(instruction),
    .OutValid(out_valid), .OutReady(out_ready), .OutInstr(out_instr),
    .OutPC(out_pc), .Halted(halted), .FetchCount(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .Start(start_w), .Redirect(1'b0),
    .RedirectPC(32'h0), .Address(address_w), .Instruction(instruction_w),
    .OutValid(out_valid_w), .OutReady(out_ready_w), .OutInstr(out_instr_w),
    .OutPC(out_pc_w), .Halted(halted_w), .FetchCount(fetch_count_w)
  );

  // Reference model: PC, run/halt flags and a queue of delivered {pc, word} pairs.
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  bit          m_run, m_halt;
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_cnt  = 16'h0;
    m_run  = 1'b0;
    m_halt = 1'b0;
    q_pc.delete();
    q_in.delete();
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit pop, fetch, idle;
    logic [31:0] w;
    pop  = (q_pc.size() > 0) && rdy;
    idle = !m_run && !m_halt;
    if (m_halt) begin
      if (pop) begin
        q_pc.delete(0);
        q_in.delete(0);
      end
    end else if (rd) begin
      q_pc.delete();
      q_in.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (idle && st) m_run = 1'b1;
    end else begin
      fetch = m_run && ((q_pc.size() < QD) || pop);
      if (pop) begin
        q_pc.delete(0);
        q_in.delete(0);
      end
      if (fetch) begin
        w = mem_word(m_pc);
        q_pc.push_back(m_pc);
        q_in.push_back(w);
        m_cnt = m_cnt + 16'd1;
        if (w == HALT) begin
          m_halt = 1'b1;
          m_run  = 1'b0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      if (idle && st) m_run = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(out_valid), 32'(q_pc.size() > 0));
    if (q_pc.size() > 0) begin
      chk("out_instr", out_instr, q_in[0]);
      chk("out_pc", out_pc, q_pc[0]);
    end
    chk("address", address, m_pc);
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
  endtask

  // One clock: drive inputs at the falling edge, advance the model, check after the edge.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    start       = st;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    model_step(st, rd, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    redirect = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    bit seen_halt;
    reset       = 1'b1;
    start       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    start_w     = 1'b0;
    out_ready_w = 1'b1;
    @(negedge clk);

    // Wrapping PC from a non-zero reset vector.
    do_reset();
    chk("w_addr_reset", address_w, 32'hFFFF_FFF8);
    start_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w = 1'b0;
    chk("w_addr_run", address_w, 32'hFFFF_FFF8);
    chk("w_valid_run", 32'(out_valid_w), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("w_addr_fc", address_w, 32'hFFFF_FFFC);
    chk("w_out_pc0", out_pc_w, 32'hFFFF_FFF8);
    @(posedge clk);
    @(negedge clk);
    chk("w_addr_wrap", address_w, 32'h0000_0000);
    chk("w_out_pc1", out_pc_w, 32'hFFFF_FFFC);

    // Streaming at one word per cycle.
    do_reset();
    step(1, 0, 0, 1);
    chk("t1_no_valid", 32'(out_valid), 32'h0);
    step(0, 0, 0, 1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_in0", out_instr, 32'h1000_0000);
    step(0, 0, 0, 1);
    chk("t1_pc1", out_pc, 32'h4);
    step(0, 0, 0, 1);
    chk("t1_pc2", out_pc, 32'h8);

    // Back-pressure fills the FIFO and stalls the PC.
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("t2_addr", address, 32'h8);
    chk("t2_fcnt", 32'(fetch_count), 32'd2);
    chk("t2_instr", out_instr, 32'h1000_0000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Redirect while full.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h0000_000E, 0);
    chk("t3_valid", 32'(out_valid), 32'h0);
    chk("t3_addr", address, 32'hC);
    step(0, 0, 0, 1);
    chk("t3_pc", out_pc, 32'hC);
    chk("t3_instr", out_instr, 32'h1000_0003);

    // Halt opcode.
    do_reset();
    step(1, 0, 0, 1);
    seen_halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1);
      if (out_valid && out_pc == 32'h18 && out_instr == HALT) seen_halt = 1'b1;
    end
    chk("t4_seen_halt", 32'(seen_halt), 32'h1);
    chk("t4_halted", 32'(halted), 32'h1);
    chk("t4_addr", address, 32'h18);
    chk("t4_fcnt", 32'(fetch_count), 32'd7);
    step(1, 1, 32'h40, 1);
    chk("t4_ignore", address, 32'h18);

    // Reset mid-stream takes effect before the next edge.
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_valid_pre", 32'(out_valid), 32'h1);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0 || (m_halt && q_pc.size() == 0 && $urandom_range(0, 3) == 0))
        do_reset();
      else
        step($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
             32'($urandom_range(0, 40)), $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
